// File: rtl/parking_gate_controller.sv
// parking_gate_controller: arbitrates one shared parking gate between an
// entry and an exit requester. It keeps an 8-slot occupancy map. An entry
// gets the lowest free slot and an exit frees the slot it names. The gate
// is held open for GATE_CYCLES after each grant. The parked, empty and full
// counts are registered.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, ties
// alternate between the two sides. When it is undefined, exit has fixed
// priority on a tie.
module parking_gate_controller #(
    parameter int GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_slot,
    output logic       entry_ack,
    output logic       exit_ack,
    output logic       exit_err,
    output logic [2:0] grant_slot,
    output logic       gate_open,
    output logic [7:0] occupancy,
    output logic [3:0] parked,
    output logic [3:0] empty,
    output logic       full
);

    typedef enum logic [1:0] {IDLE, GRANT, GATE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] occ_q, occ_d;
    logic       entry_ack_q, entry_ack_d;
    logic       exit_ack_q, exit_ack_d;
    logic       exit_err_q, exit_err_d;
    logic [2:0] grant_slot_q, grant_slot_d;
    logic       gate_open_q, gate_open_d;
    logic [3:0] parked_q, parked_d;
    logic [3:0] empty_q, empty_d;
    logic       full_q, full_d;
    logic [2:0] free_slot;
    logic       pick_entry, pick_exit;
    logic       served_entry, served_exit;

    // Find the lowest free slot. Slot 0 has the highest priority.
    always_comb begin
        free_slot = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!occ_q[i]) free_slot = 3'(i);
        end
    end

    // Count the occupied slots. The counts are registered, so they lag the map by one cycle.
    always_comb begin
        parked_d = 4'd0;
        for (int i = 0; i < 8; i++) parked_d = parked_d + {3'd0, occ_q[i]};
        empty_d = 4'd8 - parked_d;
        full_d  = (parked_d == 4'd8);
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic last_exit_q, last_exit_d;

    // Arbitrate a tie in favour of the side that was not served at the last grant.
    always_comb begin
        pick_entry  = entry_req & ~full_q & (~exit_req | last_exit_q);
        last_exit_d = last_exit_q;
        if (served_entry) last_exit_d = 1'b0;
        if (served_exit)  last_exit_d = 1'b1;
    end

    // Last-served flag. It resets to "exit" so that the first tie goes to entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_exit_q <= 1'b1;
        else     last_exit_q <= last_exit_d;
    end
`else
    // Fixed priority. Exit wins a tie because it frees capacity.
    always_comb begin
        pick_entry = entry_req & ~full_q & ~exit_req;
    end
`endif

    assign pick_exit = exit_req & ~pick_entry;

    // Next-state logic for the sequencer and the registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        occ_d        = occ_q;
        entry_ack_d  = 1'b0;
        exit_ack_d   = 1'b0;
        exit_err_d   = 1'b0;
        grant_slot_d = grant_slot_q;
        gate_open_d  = gate_open_q;
        served_entry = 1'b0;
        served_exit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_entry) begin
                    entry_ack_d         = 1'b1;
                    grant_slot_d        = free_slot;
                    occ_d[free_slot]    = 1'b1;
                    served_entry        = 1'b1;
                    state_d             = GRANT;
                end else if (pick_exit) begin
                    if (occ_q[exit_slot]) begin
                        exit_ack_d       = 1'b1;
                        occ_d[exit_slot] = 1'b0;
                        served_exit      = 1'b1;
                    end else begin
                        exit_err_d = 1'b1;
                    end
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A rejected exit returns to IDLE without a gate cycle.
                if (exit_err_q) begin
                    state_d = IDLE;
                end else begin
                    gate_open_d = 1'b1;
                    cnt_d       = 4'd1;
                    state_d     = GATE;
                end
            end
            GATE: begin
                if (cnt_q == 4'(GATE_CYCLES)) begin
                    gate_open_d = 1'b0;
                    cnt_d       = 4'd0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                gate_open_d = 1'b0;
                cnt_d       = 4'd0;
            end
        endcase
    end

    // State and output registers. Reset clears everything, including an open gate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            occ_q        <= 8'd0;
            entry_ack_q  <= 1'b0;
            exit_ack_q   <= 1'b0;
            exit_err_q   <= 1'b0;
            grant_slot_q <= 3'd0;
            gate_open_q  <= 1'b0;
            parked_q     <= 4'd0;
            empty_q      <= 4'd8;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            occ_q        <= occ_d;
            entry_ack_q  <= entry_ack_d;
            exit_ack_q   <= exit_ack_d;
            exit_err_q   <= exit_err_d;
            grant_slot_q <= grant_slot_d;
            gate_open_q  <= gate_open_d;
            parked_q     <= parked_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
        end
    end

    assign entry_ack  = entry_ack_q;
    assign exit_ack   = exit_ack_q;
    assign exit_err   = exit_err_q;
    assign grant_slot = grant_slot_q;
    assign gate_open  = gate_open_q;
    assign occupancy  = occ_q;
    assign parked     = parked_q;
    assign empty      = empty_q;
    assign full       = full_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller. It uses directed scenarios. An
// event-level model predicts every output on every cycle, and literal
// expectations pin the model to the documented scenarios.
module tb_parking_gate_controller;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_slot = 3'd0;
    logic       entry_ack, exit_ack, exit_err, gate_open, full;
    logic [2:0] grant_slot;
    logic [7:0] occupancy;
    logic [3:0] parked, empty;

    int checks = 0;
    int errors = 0;

    parking_gate_controller #(.GATE_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
        .exit_slot(exit_slot), .entry_ack(entry_ack), .exit_ack(exit_ack),
        .exit_err(exit_err), .grant_slot(grant_slot), .gate_open(gate_open),
        .occupancy(occupancy), .parked(parked), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Event-level model. Each grant reserves a busy window measured in edges.
    // The counts show the map as it stood one edge earlier.
    int         t = 0;
    logic [7:0] m_occ;
    int         m_parked, idle_from, gs, ge, e_ack_t, x_ack_t, x_err_t;
    logic [2:0] m_slot;
    bit         m_last_exit;

    always @(posedge clk or posedge rst) begin : model
        int  np;
        bit  el_e, win_e;
        if (rst) begin
            m_occ = 8'd0; m_parked = 0; idle_from = 0; gs = 1; ge = 0;
            e_ack_t = -1; x_ack_t = -1; x_err_t = -1; m_slot = 3'd0; m_last_exit = 1'b1;
        end else begin
            t++;
            np = $countones(m_occ);
            if (t >= idle_from) begin
                el_e = entry_req && (m_parked != 8);
`ifdef ARB_ROUND_ROBIN_EN
                win_e = el_e && (!exit_req || m_last_exit);
`else
                win_e = el_e && !exit_req;
`endif
                if (win_e) begin
                    for (int i = 7; i >= 0; i--) if (!m_occ[i]) m_slot = 3'(i);
                    m_occ[m_slot] = 1'b1;
                    e_ack_t = t; gs = t + 1; ge = t + G; idle_from = t + G + 2;
                    m_last_exit = 1'b0;
                end else if (exit_req) begin
                    if (m_occ[exit_slot]) begin
                        m_occ[exit_slot] = 1'b0;
                        x_ack_t = t; gs = t + 1; ge = t + G; idle_from = t + G + 2;
                        m_last_exit = 1'b1;
                    end else begin
                        x_err_t = t; idle_from = t + 2;
                    end
                end
            end
            m_parked = np;
        end
    end

    // Compare every output against the model once per cycle, away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("entry_ack", entry_ack, int'(e_ack_t == t));
            chk("exit_ack", exit_ack, int'(x_ack_t == t));
            chk("exit_err", exit_err, int'(x_err_t == t));
            chk("gate_open", gate_open, int'(t >= gs && t <= ge));
            chk("grant_slot", grant_slot, m_slot);
            chk("occupancy", occupancy, m_occ);
            chk("parked", parked, m_parked);
            chk("empty", empty, 8 - m_parked);
            chk("full", full, int'(m_parked == 8));
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // which: 0 = entry_ack, 1 = exit_ack, 2 = exit_err, 3 = exit_ack or exit_err
    task automatic wait_for(input int which, input string name);
        bit hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            case (which)
                0: hit = entry_ack;
                1: hit = exit_ack;
                2: hit = exit_err;
                default: hit = exit_ack | exit_err;
            endcase
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: timeout waiting, got 0 expected 1", name);
        end
    endtask

    task automatic do_entry(output logic [2:0] slot);
        @(negedge clk); entry_req = 1'b1;
        wait_for(0, "entry_wait");
        slot = grant_slot; entry_req = 1'b0;
    endtask

    task automatic do_exit(input logic [2:0] s);
        @(negedge clk); exit_req = 1'b1; exit_slot = s;
        wait_for(3, "exit_wait");
        exit_req = 1'b0;
    endtask

    initial begin : main
        logic [2:0] s;
        int gcnt;
        int first_entry;
        bit got_e, got_x;
        logic [2:0] tie_slot;

        // Reset state
        @(negedge clk);
        chk("rst_occ", occupancy, 0); chk("rst_empty", empty, 8); chk("rst_parked", parked, 0);
        chk("rst_full", full, 0); chk("rst_gate", gate_open, 0); chk("rst_slot", grant_slot, 0);
        chk("rst_acks", {entry_ack, exit_ack, exit_err}, 0);
        rst = 1'b0;

        // 1: single entry, latency and gate length
        @(negedge clk); entry_req = 1'b1;
        @(negedge clk);
        chk("t1_ack", entry_ack, 1); chk("t1_slot", grant_slot, 0); chk("t1_occ", occupancy, 8'h01);
        chk("t1_gate_not_yet", gate_open, 0);
        entry_req = 1'b0;
        gcnt = 0;
        @(negedge clk);
        chk("t1_parked", parked, 1); chk("t1_empty", empty, 7);
        for (int k = 0; k < 10; k++) begin
            if (gate_open) gcnt++;
            @(negedge clk);
        end
        chk("t1_gate_len", gcnt, G);

        // 2: eight entries fill the map, and a ninth entry stays pending
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_entry(s);
            chk("t2_slot", s, i);
        end
        entry_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("t2_pending", entry_ack, 0);
        end
        chk("t2_occ", occupancy, 8'hFF); chk("t2_full", full, 1);

        // 3: exit slot 3 while the entry is still pending
        exit_req = 1'b1; exit_slot = 3'd3;
        wait_for(1, "t3_exit_wait");
        exit_req = 1'b0;
        chk("t3_occ", occupancy, 8'hF7);
        @(negedge clk);
        chk("t3_parked", parked, 7); chk("t3_full", full, 0);
        wait_for(0, "t3_entry_wait");
        chk("t3_slot", grant_slot, 3);
        entry_req = 1'b0;

        // 4: an exit from a free slot is rejected
        do_reset();
        do_entry(s); do_entry(s); do_exit(3'd1);   // occ=01, last served = exit
        repeat (8) @(negedge clk);
        chk("t4_occ_pre", occupancy, 8'h01);
        exit_req = 1'b1; exit_slot = 3'd5;
        wait_for(2, "t4_err_wait");
        exit_req = 1'b0;
        gcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (gate_open) gcnt++;
        end
        chk("t4_no_gate", gcnt, 0); chk("t4_occ", occupancy, 8'h01);

        // 5: entry and exit requested on the same cycle
        entry_req = 1'b1; exit_req = 1'b1; exit_slot = 3'd0;
        got_e = 0; got_x = 0; first_entry = -1; tie_slot = 3'd7;
        for (int k = 0; k < 200 && !(got_e && got_x); k++) begin
            @(negedge clk);
            if (entry_ack) begin
                got_e = 1; tie_slot = grant_slot; entry_req = 1'b0;
                if (first_entry < 0) first_entry = 1;
            end
            if (exit_ack) begin
                got_x = 1; exit_req = 1'b0;
                if (first_entry < 0) first_entry = 0;
            end
        end
        entry_req = 1'b0; exit_req = 1'b0;
        chk("t5_both_done", int'(got_e && got_x), 1);
`ifdef ARB_ROUND_ROBIN_EN
        chk("t5_first_entry", first_entry, 1); chk("t5_slot", tie_slot, 1);
        repeat (8) @(negedge clk);
        chk("t5_occ", occupancy, 8'h02);
`else
        chk("t5_first_entry", first_entry, 0); chk("t5_slot", tie_slot, 0);
        repeat (8) @(negedge clk);
        chk("t5_occ", occupancy, 8'h01);
`endif

        // 6: asynchronous reset in the middle of a gate cycle
        do_reset();
        for (int i = 0; i < 4; i++) do_entry(s);
        @(posedge clk); @(posedge clk);
        #1;
        chk("t6_gate_pre", gate_open, 1); chk("t6_occ_pre", occupancy, 8'h0F);
        rst = 1'b1;
        #1;
        chk("t6_gate", gate_open, 0); chk("t6_occ", occupancy, 0); chk("t6_empty", empty, 8);
        @(negedge clk); rst = 1'b0;
        do_entry(s);
        chk("t6_slot", s, 0);
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
